instr_decode_stage: RTL and testbench
=====================================

// Module: instr_decode_stage
// PURPOSE
//  Pipelined RV32I/RV64I decode stage between fetch and register-read/execute.
//  Splits a 32-bit instruction into fields, builds a sign-extended XLEN immediate and derives
//  format, register-enable and illegal flags. Uses a valid/ready handshake, an optional skid
//  buffer and a flush, so fetch and execute stall independently.
// PARAMETERS
//  XLEN     32  datapath width for out_imm and pc; legal values are 32 or 64.
//  SKID_EN  1   1: 2-entry output (main + skid), in_ready is a flop. 0: single register, in_ready is combinational.
//  ZERO_X   1   1: unused fields are driven to 0. 0: unused fields are driven to 'x (simulation only).
// PORTS
//  clk          in   1     rising-edge clock.
//  reset        in   1     synchronous, active-high.
//  flush        in   1     discard all held and incoming instructions.
//  in_valid     in   1     fetch holds a valid instruction.
//  in_ready     out  1     decode accepts this cycle. Transfer = in_valid & in_ready.
//  in_instr     in   32    raw instruction.
//  in_pc        in   XLEN  pc of in_instr.
//  out_valid    out  1     decoded bundle is valid.
//  out_ready    in   1     downstream accepts. Transfer = out_valid & out_ready.
//  out_pc       out  XLEN  registered pc.
//  out_opcode   out  7     instr[6:0].
//  out_fmt      out  3     R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
//  out_rd/rs1/rs2  out  5  register indices.
//  out_func3    out  3     instr[14:12].
//  out_func7    out  7     instr[31:25]; R format only.
//  out_imm      out  XLEN  sign-extended immediate.
//  out_rs1_en, out_rs2_en  out 1  source register is read.
//  out_rd_we    out  1     writes rd; forced to 0 when rd == x0.
//  out_illegal  out  1     illegal encoding.
// BEHAVIOUR
//  - Reset: out_valid = 0, skid empty, in_ready = 1 in the first cycle after reset; all payload outputs = 0.
//  - Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N when the output is free.
//  - Opcode to format:
//    - OP 0110011 -> R.
//    - OP_IMM 0010011, LOAD 0000011, JALR 1100111, MISC_MEM 0001111, SYSTEM 1110011 -> I.
//    - STORE 0100011 -> S. BRANCH 1100011 -> B. LUI 0110111, AUIPC 0010111 -> U. JAL 1101111 -> J.
//    - Any other opcode -> ILL.
//  - Immediates: every immediate sign-extends from instr[31] to XLEN.
//    - I: instr[31:20].  S: {instr[31:25], instr[11:7]}.
//    - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
//    - U: {instr[31:12], 12'b0}.  J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
//    - R and ILL: imm = 0.
//  - Enables:
//    - rs1_en: R, I, S, B.  rs2_en: R, S, B.
//    - rd_we: R, I, U, J with rd != 0. Never set for ILL.
//    - A field whose enable is clear is driven per ZERO_X.
//  - illegal = 1 when any of these holds:
//    - instr[1:0] != 2'b11.
//    - fmt == ILL.
//    - R format with func7 not in {0000000, 0100000}.
//    - JALR with func3 != 0.
//    - BRANCH with func3 in {010, 011}.
//    An illegal instruction still flows through with out_valid = 1 and all enables = 0.
//  - Handshake, SKID_EN = 0:
//    - in_ready = !out_valid | out_ready.
//    - On an input transfer the main register loads. Otherwise an output transfer clears out_valid.
//  - Handshake, SKID_EN = 1:
//    - in_ready = !skid_valid (flop).
//    - Input transfer while out_valid & !out_ready -> entry goes to skid, skid_valid = 1.
//    - Output transfer with skid_valid -> skid moves to main, skid_valid = 0; a new input goes to skid.
//    - Output transfer while skid empty and an input transfer -> input goes to main.
//    - Order is strict FIFO. No drop or duplicate under any in_valid/out_ready pattern.
//    - out_* must hold stable while out_valid & !out_ready.
//  - Flush has priority over every handshake:
//    - Next cycle out_valid = 0, skid empty, in_ready = 1.
//    - An input transferred in the flush cycle is discarded.
//  - Reset overrides flush. Reset mid-stall discards all content.
// STRUCTURE
//  - Package rv_decode_pkg holds:
//    - opcode localparams (OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
//      OPC_LUI, OPC_AUIPC, OPC_MISC_MEM, OPC_SYSTEM);
//    - FMT_* codes;
//    - the decoded-bundle struct, used for the main and skid registers.
//  - Sub-module rv_imm_gen #(XLEN): combinational; inputs instr and fmt, output imm.
//  - The top holds the field decode, illegal check and handshake/skid registers.
// TESTING
//  1. Reset, then in_instr = 32'h00500093 (addi x1,x0,5) with out_ready = 1
//     -> next cycle: fmt = I, rd = 1, rs1 = 0, imm = 5, rd_we = 1, rs1_en = 1, rs2_en = 0.
//  2. Immediates:
//     - 32'hFFF00113 (addi x2,x0,-1) -> imm = all ones at XLEN 32 and at XLEN 64.
//     - 32'hFE000EE3 (beq x0,x0,-4) -> fmt = B, imm = -4.
//     - 32'h800000EF (jal, min offset) -> imm = -1048576.
//     - 32'h12345037 (lui) -> imm = 32'h12345000.
//  3. Illegal cases, each giving illegal = 1, out_valid = 1 and all enables = 0:
//     - 32'h00000000;
//     - 32'hFFFFFFFF;
//     - R format with func7 = 0000001;
//     - JALR with func3 = 1.
//  4. Backpressure, SKID_EN = 1: stream 8 instructions while out_ready toggles randomly, then holds 0 for 3 cycles
//     -> in_ready falls exactly when skid fills; output order and count match; no loss.
//  5. Flush with both entries full and in_valid = 1 in the same cycle -> next cycle out_valid = 0, in_ready = 1;
//     the next accepted instruction is the first one output.
//  6. rd = 0: 32'h00000013 (nop) -> rd_we = 0. Repeat tests 1-4 with SKID_EN = 0 and ZERO_X = 1.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV32I/RV64I decode definitions: opcodes, format codes, the decoded-field bundle
// and the opcode-to-format mapping.
package rv_decode_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // XLEN-independent part of a decoded instruction; pc/imm are added by the top.
    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] fmt;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] func3;
        logic [6:0] func7;
        logic       rs1_en;
        logic       rs2_en;
        logic       rd_we;
        logic       illegal;
    } decoded_t;

    function automatic logic [2:0] opcode_fmt(input logic [6:0] opc);
        case (opc)
            OPC_OP:                                  return FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_MISC_MEM, OPC_SYSTEM:                return FMT_I;
            OPC_STORE:                               return FMT_S;
            OPC_BRANCH:                              return FMT_B;
            OPC_LUI, OPC_AUIPC:                      return FMT_U;
            OPC_JAL:                                 return FMT_J;
            default:                                 return FMT_ILL;
        endcase
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate generator: assembles the format-specific immediate and sign-extends it to XLEN.
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Every 32-bit immediate already carries instr[31] in bit 31, so widen from there.
    always_comb begin
        imm       = {XLEN{imm32[31]}};
        imm[31:0] = imm32;
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: field split, illegal check and a 1- or 2-entry valid/ready output buffer
// with flush.
module instr_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1,
    parameter bit ZERO_X  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_fmt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_rs1_en,
    output logic            out_rs2_en,
    output logic            out_rd_we,
    output logic            out_illegal
);

    localparam logic [4:0] FILL5 = ZERO_X ? 5'd0 : 5'bx;
    localparam logic [6:0] FILL7 = ZERO_X ? 7'd0 : 7'bx;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        decoded_t        d;
    } bundle_t;

    logic [6:0]      opcode;
    logic [2:0]      fmt;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic            illegal;
    logic [XLEN-1:0] imm;
    bundle_t         dec;
    bundle_t         main_q;
    bundle_t         skid_q;
    logic            valid_q;
    logic            skid_valid;
    logic            in_xfer;

    assign opcode = in_instr[6:0];
    assign func3  = in_instr[14:12];
    assign func7  = in_instr[31:25];
    assign fmt    = opcode_fmt(opcode);

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm)
    );

    always_comb begin
        illegal = (in_instr[1:0] != 2'b11)
               || (fmt == FMT_ILL)
               || (fmt == FMT_R && func7 != 7'b0000000 && func7 != 7'b0100000)
               || (opcode == OPC_JALR && func3 != 3'b000)
               || (opcode == OPC_BRANCH && (func3 == 3'b010 || func3 == 3'b011));
    end

    always_comb begin
        dec          = '0;
        dec.pc       = in_pc;
        dec.imm      = imm;
        dec.d.opcode = opcode;
        dec.d.fmt    = fmt;
        dec.d.func3  = func3;
        dec.d.illegal = illegal;
        dec.d.rs1_en = !illegal && (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B});
        dec.d.rs2_en = !illegal && (fmt inside {FMT_R, FMT_S, FMT_B});
        dec.d.rd_we  = !illegal && (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (in_instr[11:7] != 5'd0);
        dec.d.rd     = dec.d.rd_we  ? in_instr[11:7]  : FILL5;
        dec.d.rs1    = dec.d.rs1_en ? in_instr[19:15] : FILL5;
        dec.d.rs2    = dec.d.rs2_en ? in_instr[24:20] : FILL5;
        dec.d.func7  = (fmt == FMT_R && !illegal) ? func7 : FILL7;
    end

    // The skid only fills while main is valid, so !skid_valid also means "room for one more".
    assign in_ready = SKID_EN ? !skid_valid : (!valid_q || out_ready);
    assign in_xfer  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            valid_q    <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            valid_q    <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!valid_q || out_ready) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                main_q  <= dec;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_opcode  = main_q.d.opcode;
    assign out_fmt     = main_q.d.fmt;
    assign out_rd      = main_q.d.rd;
    assign out_rs1     = main_q.d.rs1;
    assign out_rs2     = main_q.d.rs2;
    assign out_func3   = main_q.d.func3;
    assign out_func7   = main_q.d.func7;
    assign out_rs1_en  = main_q.d.rs1_en;
    assign out_rs2_en  = main_q.d.rs2_en;
    assign out_rd_we   = main_q.d.rd_we;
    assign out_illegal = main_q.d.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench: a = XLEN32/skid, d = XLEN64/skid, c = XLEN32/no skid, all on shared inputs.
module tb_instr_decode_stage;
    import rv_decode_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [63:0] in_pc64;
    int          total = 0;
    int          bad = 0;
    bit          sel = 1'b0;

    always #5 clk = ~clk;
    assign in_pc64 = {32'h0, in_pc};

    logic a_rdy, a_vld, a_rs1_en, a_rs2_en, a_we, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [6:0] a_opc, a_f7;
    logic [2:0] a_fmt, a_f3;
    logic [4:0] a_rd, a_rs1, a_rs2;

    logic c_rdy, c_vld, c_rs1_en, c_rs2_en, c_we, c_ill;
    logic [31:0] c_pc, c_imm;
    logic [6:0] c_opc, c_f7;
    logic [2:0] c_fmt, c_f3;
    logic [4:0] c_rd, c_rs1, c_rs2;

    logic d_rdy, d_vld, d_rs1_en, d_rs2_en, d_we, d_ill;
    logic [63:0] d_pc, d_imm;
    logic [6:0] d_opc, d_f7;
    logic [2:0] d_fmt, d_f3;
    logic [4:0] d_rd, d_rs1, d_rs2;

    instr_decode_stage #(.XLEN(32), .SKID_EN(1), .ZERO_X(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_rdy),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_vld), .out_ready(out_ready),
        .out_pc(a_pc), .out_opcode(a_opc), .out_fmt(a_fmt), .out_rd(a_rd), .out_rs1(a_rs1),
        .out_rs2(a_rs2), .out_func3(a_f3), .out_func7(a_f7), .out_imm(a_imm),
        .out_rs1_en(a_rs1_en), .out_rs2_en(a_rs2_en), .out_rd_we(a_we), .out_illegal(a_ill));

    instr_decode_stage #(.XLEN(32), .SKID_EN(0), .ZERO_X(1)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_rdy),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(c_vld), .out_ready(out_ready),
        .out_pc(c_pc), .out_opcode(c_opc), .out_fmt(c_fmt), .out_rd(c_rd), .out_rs1(c_rs1),
        .out_rs2(c_rs2), .out_func3(c_f3), .out_func7(c_f7), .out_imm(c_imm),
        .out_rs1_en(c_rs1_en), .out_rs2_en(c_rs2_en), .out_rd_we(c_we), .out_illegal(c_ill));

    instr_decode_stage #(.XLEN(64), .SKID_EN(1), .ZERO_X(1)) dut_d (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(d_rdy),
        .in_instr(in_instr), .in_pc(in_pc64), .out_valid(d_vld), .out_ready(out_ready),
        .out_pc(d_pc), .out_opcode(d_opc), .out_fmt(d_fmt), .out_rd(d_rd), .out_rs1(d_rs1),
        .out_rs2(d_rs2), .out_func3(d_f3), .out_func7(d_f7), .out_imm(d_imm),
        .out_rs1_en(d_rs1_en), .out_rs2_en(d_rs2_en), .out_rd_we(d_we), .out_illegal(d_ill));

    // View of whichever 32-bit DUT a streaming test is driving.
    logic m_rdy, m_vld;
    logic [31:0] m_pc;
    logic [4:0] m_rd;
    always_comb begin
        m_rdy = sel ? c_rdy : a_rdy;
        m_vld = sel ? c_vld : a_vld;
        m_pc  = sel ? c_pc  : a_pc;
        m_rd  = sel ? c_rd  : a_rd;
    end

    function automatic logic [31:0] mk(input int i);
        return {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13};   // addi x(i+1), x0, i
    endfunction

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic decode_one(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1; out_ready = 1'b1; in_instr = instr; in_pc = pc;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total += 8;
        if (a_vld !== 1'b0) begin bad++; $display("FAIL reset_a_valid: got %b want 0", a_vld); end
        if (a_rdy !== 1'b1) begin bad++; $display("FAIL reset_a_ready: got %b want 1", a_rdy); end
        if (a_pc !== 32'h0) begin bad++; $display("FAIL reset_a_pc: got %h want 0", a_pc); end
        if (a_imm !== 32'h0) begin bad++; $display("FAIL reset_a_imm: got %h want 0", a_imm); end
        if ({a_rd, a_we, a_fmt} !== 9'h0) begin bad++; $display("FAIL reset_a_fields: got %h want 0", {a_rd, a_we, a_fmt}); end
        if (c_vld !== 1'b0) begin bad++; $display("FAIL reset_c_valid: got %b want 0", c_vld); end
        if (c_rdy !== 1'b1) begin bad++; $display("FAIL reset_c_ready: got %b want 1", c_rdy); end
        if (d_imm !== 64'h0) begin bad++; $display("FAIL reset_d_imm: got %h want 0", d_imm); end
    endtask

    task automatic test_addi();
        do_reset();
        decode_one(32'h00500093, 32'h0000_0100);
        total += 10;
        if (a_vld !== 1'b1) begin bad++; $display("FAIL addi_valid: got %b want 1", a_vld); end
        if (a_fmt !== FMT_I) begin bad++; $display("FAIL addi_fmt: got %0d want 1", a_fmt); end
        if (a_rd !== 5'd1) begin bad++; $display("FAIL addi_rd: got %0d want 1", a_rd); end
        if (a_rs1 !== 5'd0) begin bad++; $display("FAIL addi_rs1: got %0d want 0", a_rs1); end
        if (a_imm !== 32'd5) begin bad++; $display("FAIL addi_imm: got %h want 5", a_imm); end
        if ({a_we, a_rs1_en, a_rs2_en} !== 3'b110) begin bad++; $display("FAIL addi_en: got %b want 110", {a_we, a_rs1_en, a_rs2_en}); end
        if (a_pc !== 32'h100) begin bad++; $display("FAIL addi_pc: got %h want 100", a_pc); end
        if (c_vld !== 1'b1 || c_rd !== 5'd1 || c_imm !== 32'd5) begin
            bad++; $display("FAIL addi_c: got v=%b rd=%0d imm=%h want v=1 rd=1 imm=5", c_vld, c_rd, c_imm);
        end
        if ({c_we, c_rs1_en, c_rs2_en} !== 3'b110) begin bad++; $display("FAIL addi_c_en: got %b want 110", {c_we, c_rs1_en, c_rs2_en}); end
        if (d_pc !== 64'h100) begin bad++; $display("FAIL addi_d_pc: got %h want 100", d_pc); end
    endtask

    task automatic test_imm();
        logic [31:0] ins [7] = '{32'h00500093, 32'hFFF00113, 32'hFE000EE3, 32'h800000EF,
                                 32'h12345037, 32'h0020A423, 32'h002081B3};
        logic [31:0] imm [7] = '{32'h5, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFF00000,
                                 32'h12345000, 32'h8, 32'h0};
        logic [2:0]  fm  [7] = '{FMT_I, FMT_I, FMT_B, FMT_J, FMT_U, FMT_S, FMT_R};
        logic [63:0] e64;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            decode_one(ins[i], 32'h200 + 32'(i * 4));
            e64 = {{32{imm[i][31]}}, imm[i]};
            total += 4;
            if (a_imm !== imm[i]) begin bad++; $display("FAIL imm32_%0d: got %h want %h", i, a_imm, imm[i]); end
            if (d_imm !== e64) begin bad++; $display("FAIL imm64_%0d: got %h want %h", i, d_imm, e64); end
            if (a_fmt !== fm[i]) begin bad++; $display("FAIL fmt_%0d: got %0d want %0d", i, a_fmt, fm[i]); end
            if (c_imm !== imm[i]) begin bad++; $display("FAIL imm_c_%0d: got %h want %h", i, c_imm, imm[i]); end
        end
        // add x3,x1,x2 is the last vector: check R-type fields
        total += 2;
        if ({a_rd, a_rs1, a_rs2} !== {5'd3, 5'd1, 5'd2}) begin
            bad++; $display("FAIL r_regs: got %0d/%0d/%0d want 3/1/2", a_rd, a_rs1, a_rs2);
        end
        if ({a_we, a_rs1_en, a_rs2_en, a_ill} !== 4'b1110) begin
            bad++; $display("FAIL r_en: got %b want 1110", {a_we, a_rs1_en, a_rs2_en, a_ill});
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [5] = '{32'h00000000, 32'hFFFFFFFF, 32'h023100B3, 32'h000110E7, 32'h0000A063};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            decode_one(ins[i], 32'h300);
            total += 3;
            if (a_ill !== 1'b1 || a_vld !== 1'b1) begin
                bad++; $display("FAIL ill_%0d: got ill=%b v=%b want ill=1 v=1", i, a_ill, a_vld);
            end
            if ({a_we, a_rs1_en, a_rs2_en} !== 3'b000) begin
                bad++; $display("FAIL ill_en_%0d: got %b want 000", i, {a_we, a_rs1_en, a_rs2_en});
            end
            if (c_ill !== 1'b1 || {c_we, c_rs1_en, c_rs2_en} !== 3'b000) begin
                bad++; $display("FAIL ill_c_%0d: got ill=%b en=%b want ill=1 en=000", i, c_ill, {c_we, c_rs1_en, c_rs2_en});
            end
        end
        total++;
        decode_one(32'hFFFFFFFF, 32'h300);
        if (a_fmt !== FMT_ILL) begin bad++; $display("FAIL ill_fmt: got %0d want 7", a_fmt); end
    endtask

    task automatic test_rd_zero();
        do_reset();
        decode_one(32'h00000013, 32'h400);
        total += 2;
        if (a_we !== 1'b0 || a_rs1_en !== 1'b1) begin bad++; $display("FAIL nop_we: got we=%b rs1_en=%b want we=0 rs1_en=1", a_we, a_rs1_en); end
        if (c_we !== 1'b0 || c_ill !== 1'b0) begin bad++; $display("FAIL nop_c: got we=%b ill=%b want 0 0", c_we, c_ill); end
        decode_one(32'h0020A423, 32'h404);   // sw: no rd, so rd field zeroed
        total += 1;
        if ({a_rd, a_we, a_rs2_en, a_rs2} !== {5'd0, 1'b0, 1'b1, 5'd2}) begin
            bad++; $display("FAIL store_fields: got rd=%0d we=%b rs2_en=%b rs2=%0d want 0 0 1 2", a_rd, a_we, a_rs2_en, a_rs2);
        end
    endtask

    task automatic test_backpressure(input bit s);
        int sent = 0, rcvd = 0, occ = 0, hold = 0, cyc;
        bit ix, ox, exp_rdy;
        sel = s;
        do_reset();
        for (cyc = 0; cyc < 150 && rcvd < 8; cyc++) begin
            in_valid = (sent < 8);
            in_instr = mk(sent);
            in_pc    = 32'h1000 + 32'(sent * 4);
            if (sent < 5)      out_ready = 1'($urandom_range(0, 1));
            else if (hold < 3) begin out_ready = 1'b0; hold++; end
            else               out_ready = 1'b1;
            @(negedge clk);
            exp_rdy = s ? (occ == 0 || out_ready) : (occ < 2);
            total += 2;
            if (m_rdy !== exp_rdy) begin bad++; $display("FAIL bp%0d_ready c%0d: got %b want %b", s, cyc, m_rdy, exp_rdy); end
            if (m_vld !== (occ > 0)) begin bad++; $display("FAIL bp%0d_valid c%0d: got %b want %b", s, cyc, m_vld, occ > 0); end
            ix = in_valid && m_rdy;
            ox = m_vld && out_ready;
            if (ox) begin
                total += 2;
                if (m_pc !== 32'h1000 + 32'(rcvd * 4)) begin bad++; $display("FAIL bp%0d_pc #%0d: got %h want %h", s, rcvd, m_pc, 32'h1000 + 32'(rcvd * 4)); end
                if (m_rd !== 5'(rcvd + 1)) begin bad++; $display("FAIL bp%0d_rd #%0d: got %0d want %0d", s, rcvd, m_rd, rcvd + 1); end
                rcvd++;
            end
            if (ix) sent++;
            occ = occ + int'(ix) - int'(ox);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++;
        if (sent != 8 || rcvd != 8) begin bad++; $display("FAIL bp%0d_count: got sent=%0d rcvd=%0d want 8 8", s, sent, rcvd); end
    endtask

    task automatic test_flush();
        sel = 1'b0;
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        in_instr = mk(0); in_pc = 32'h500;
        @(posedge clk); #1;
        in_instr = mk(1); in_pc = 32'h504;
        @(posedge clk); #1;
        total += 2;
        if (a_rdy !== 1'b0 || a_vld !== 1'b1) begin bad++; $display("FAIL flush_full: got rdy=%b v=%b want 0 1", a_rdy, a_vld); end
        if (a_pc !== 32'h500) begin bad++; $display("FAIL flush_hold_pc: got %h want 500", a_pc); end
        in_instr = mk(2); in_pc = 32'h508; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        total += 2;
        if (a_vld !== 1'b0 || a_rdy !== 1'b1) begin bad++; $display("FAIL flush_a: got v=%b rdy=%b want 0 1", a_vld, a_rdy); end
        if (c_vld !== 1'b0 || c_rdy !== 1'b1) begin bad++; $display("FAIL flush_c: got v=%b rdy=%b want 0 1", c_vld, c_rdy); end
        decode_one(mk(5), 32'h2000);
        total += 2;
        if (a_vld !== 1'b1 || a_pc !== 32'h2000 || a_rd !== 5'd6) begin
            bad++; $display("FAIL flush_next_a: got v=%b pc=%h rd=%0d want 1 2000 6", a_vld, a_pc, a_rd);
        end
        if (c_vld !== 1'b1 || c_pc !== 32'h2000) begin bad++; $display("FAIL flush_next_c: got v=%b pc=%h want 1 2000", c_vld, c_pc); end
        @(posedge clk); #1;
        total++;
        if (a_vld !== 1'b0) begin bad++; $display("FAIL flush_drain: got %b want 0", a_vld); end
        // input offered into an empty stage during flush must be discarded
        in_valid = 1'b1; in_instr = mk(7); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        total++;
        if (a_vld !== 1'b0 || c_vld !== 1'b0 || d_vld !== 1'b0) begin
            bad++; $display("FAIL flush_drop: got a=%b c=%b d=%b want 0 0 0", a_vld, c_vld, d_vld);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_imm();
        test_illegal();
        test_rd_zero();
        test_backpressure(1'b0);
        test_backpressure(1'b1);
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
